// File: rtl/rom_seq_reader.sv
// Walks a combinational ROM from word 0 to the last word at one step per DIV clocks,
// capturing each word with a one-cycle valid strobe; stops or wraps at the end of a pass.
module rom_seq_reader #(
   parameter int AW  = 2,
   parameter int DW  = 4,
   parameter int DIV = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          stop,
   input  logic          loop,
   input  logic [DW-1:0] rom_data,
   output logic [AW-1:0] adr,
   output logic [DW-1:0] data,
   output logic          data_valid,
   output logic          busy,
   output logic          done,
   output logic [7:0]    passes
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [7:0]    CNT_LAST = 8'(DIV - 1);
   localparam logic [AW-1:0] ADR_LAST = {AW{1'b1}};

   state_t        state_q, state_d;
   logic [AW-1:0] adr_q, adr_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [DW-1:0] data_q, data_d;
   logic          data_valid_q, data_valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [7:0]    passes_q, passes_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         adr_q        <= '0;
         cnt_q        <= '0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         passes_q     <= '0;
      end else begin
         state_q      <= state_d;
         adr_q        <= adr_d;
         cnt_q        <= cnt_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         passes_q     <= passes_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      adr_d        = adr_q;
      cnt_d        = cnt_q;
      data_d       = data_q;
      data_valid_d = 1'b0;
      done_d       = 1'b0;
      passes_d     = passes_q;

      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d  = RUN;
               adr_d    = '0;
               cnt_d    = '0;
               passes_d = '0;
            end
         end
         RUN: begin
            // stop outranks a coinciding step edge, so an aborted step never captures
            if (stop) begin
               state_d = IDLE;
               adr_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q < CNT_LAST) begin
               cnt_d = cnt_q + 8'd1;
            end else begin
               data_d       = rom_data;
               data_valid_d = 1'b1;
               cnt_d        = '0;
               if (adr_q != ADR_LAST) begin
                  adr_d = adr_q + AW'(1);
               end else begin
                  adr_d    = '0;
                  passes_d = passes_q + 8'd1;
                  if (!loop) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
   end

   assign adr        = adr_q;
   assign data       = data_q;
   assign data_valid = data_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign passes     = passes_q;

endmodule

// File: tb/tb_rom_seq_reader.sv
// Bench for rom_seq_reader: a DIV=4 and a DIV=1 instance against a 4-word ROM model,
// with captured words scored against an expected-data queue per instance.
module tb_rom_seq_reader;

   logic       clk;
   logic       rst_n;
   logic       stop;
   logic       loop;
   logic       start_a, start_b;
   logic [1:0] adr_a, adr_b;
   logic [3:0] rom_a, rom_b;
   logic [3:0] data_a, data_b;
   logic       dv_a, dv_b;
   logic       busy_a, busy_b;
   logic       done_a, done_b;
   logic [7:0] passes_a, passes_b;

   int n_chk  = 0;
   int n_fail = 0;
   int q_a[$];
   int q_b[$];
   int words[4] = '{3, 7, 12, 5};

   function automatic logic [3:0] rom_word(input logic [1:0] a);
      case (a)
         2'd0:    rom_word = 4'd3;
         2'd1:    rom_word = 4'd7;
         2'd2:    rom_word = 4'd12;
         default: rom_word = 4'd5;
      endcase
   endfunction

   assign rom_a = rom_word(adr_a);
   assign rom_b = rom_word(adr_b);

   rom_seq_reader #(.AW(2), .DW(4), .DIV(4)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop), .loop(loop),
      .rom_data(rom_a), .adr(adr_a), .data(data_a), .data_valid(dv_a),
      .busy(busy_a), .done(done_a), .passes(passes_a)
   );

   rom_seq_reader #(.AW(2), .DW(4), .DIV(1)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop), .loop(loop),
      .rom_data(rom_b), .adr(adr_b), .data(data_b), .data_valid(dv_b),
      .busy(busy_b), .done(done_b), .passes(passes_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // One clock; observe just after the edge and score any captured word.
   task automatic tick();
      @(posedge clk);
      #1;
      if (dv_a) begin
         chk("a_valid_expected", int'(dv_a), int'(q_a.size() != 0));
         if (q_a.size() != 0) chk("a_data", int'(data_a), q_a.pop_front());
      end
      if (dv_b) begin
         chk("b_valid_expected", int'(dv_b), int'(q_b.size() != 0));
         if (q_b.size() != 0) chk("b_data", int'(data_b), q_b.pop_front());
      end
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_adr"},    int'(adr_a),    0);
      chk({tag, "_data"},   int'(data_a),   0);
      chk({tag, "_dv"},     int'(dv_a),     0);
      chk({tag, "_busy"},   int'(busy_a),   0);
      chk({tag, "_done"},   int'(done_a),   0);
      chk({tag, "_passes"}, int'(passes_a), 0);
   endtask

   // Single non-looping pass on the DIV=4 instance; start stays high through cycle hold.
   task automatic run_pass_a(input int hold);
      foreach (words[i]) q_a.push_back(words[i]);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      if (hold == 0) start_a = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (c >= hold) start_a = 1'b0;
         chk($sformatf("a_dv_c%0d", c),   int'(dv_a),   int'(c % 4 == 0));
         chk($sformatf("a_done_c%0d", c), int'(done_a), int'(c == 16));
         chk($sformatf("a_busy_c%0d", c), int'(busy_a), int'(c < 16));
         chk($sformatf("a_adr_c%0d", c),  int'(adr_a),  (c / 4) % 4);
      end
      chk("a_pass_passes", int'(passes_a), 1);
      chk("a_pass_queue_empty", q_a.size(), 0);
   endtask

   initial begin
      rst_n   = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      stop    = 1'b0;
      loop    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_a("rst");
      chk("rst_b_busy", int'(busy_b), 0);
      rst_n = 1'b1;
      tick();

      // Single pass.
      run_pass_a(0);

      // Loop mode, started in the first IDLE cycle after done.
      loop = 1'b1;
      for (int n = 0; n < 9; n++) q_a.push_back(words[n % 4]);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      for (int c = 1; c <= 36; c++) begin
         tick();
         chk($sformatf("loop_dv_c%0d", c),  int'(dv_a),   int'(c % 4 == 0));
         chk($sformatf("loop_done_c%0d", c), int'(done_a), 0);
         chk($sformatf("loop_busy_c%0d", c), int'(busy_a), 1);
         chk($sformatf("loop_adr_c%0d", c),  int'(adr_a),  (c / 4) % 4);
      end
      chk("loop_passes", int'(passes_a), 2);
      chk("loop_queue_empty", q_a.size(), 0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      loop = 1'b0;
      chk("loop_stop_busy", int'(busy_a), 0);
      chk("loop_stop_adr", int'(adr_a), 0);
      chk("loop_stop_done", int'(done_a), 0);
      chk("loop_stop_passes", int'(passes_a), 2);

      // Stop mid-pass, asserted in cycle 6.
      q_a.push_back(3);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      for (int c = 1; c <= 6; c++) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_busy", int'(busy_a), 0);
      chk("stop_adr", int'(adr_a), 0);
      chk("stop_data", int'(data_a), 3);
      chk("stop_passes", int'(passes_a), 0);
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("stop_after_dv", int'(dv_a), 0);
         chk("stop_after_done", int'(done_a), 0);
      end
      chk("stop_queue_empty", q_a.size(), 0);

      // start and stop together in IDLE.
      start_a = 1'b1;
      stop    = 1'b1;
      tick();
      tick();
      chk("coll_idle_busy", int'(busy_a), 0);
      chk("coll_idle_adr", int'(adr_a), 0);
      start_a = 1'b0;
      stop    = 1'b0;
      tick();

      // stop on a step edge: present in cycle 7, sampled on the edge where cnt == DIV-1.
      q_a.push_back(3);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      for (int c = 1; c <= 7; c++) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("coll_step_dv", int'(dv_a), 0);
      chk("coll_step_data", int'(data_a), 3);
      chk("coll_step_busy", int'(busy_a), 0);
      for (int c = 0; c < 6; c++) tick();
      chk("coll_step_queue_empty", q_a.size(), 0);

      // start held high while running.
      run_pass_a(9);

      // DIV = 1 instance.
      foreach (words[i]) q_b.push_back(words[i]);
      start_b = 1'b1;
      @(posedge clk);
      #1;
      start_b = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         tick();
         chk($sformatf("b_dv_c%0d", c),   int'(dv_b),   int'(c <= 4));
         chk($sformatf("b_done_c%0d", c), int'(done_b), int'(c == 4));
         chk($sformatf("b_busy_c%0d", c), int'(busy_b), int'(c < 4));
      end
      chk("b_passes", int'(passes_b), 1);
      chk("b_queue_empty", q_b.size(), 0);

      // Asynchronous reset dropped between edges during cycle 10.
      foreach (words[i]) q_a.push_back(words[i]);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      for (int c = 1; c <= 10; c++) tick();
      chk("arst_pre_busy", int'(busy_a), 1);
      chk("arst_pre_data", int'(data_a), 7);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_a("arst");
      q_a.delete();
      @(posedge clk);
      #1;
      chk("arst_hold_busy", int'(busy_a), 0);
      chk("arst_hold_done", int'(done_a), 0);
      rst_n = 1'b1;
      tick();
      run_pass_a(0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
